fb_pattern_writer: RTL and testbench

Parametrised successor to the top-level test-pattern writer that feeds the SDRAM/VGA controller's CPU write port. It walks a rectangular H_RES x V_RES region at a configurable base and line stride, and generates one of four pixel patterns. It paces writes and holds each write under a ready handshake until it is accepted. Start, abort and done controls let a CPU or a key debouncer drive it.

---
 rtl/fb_pattern_writer_if.sv | 28 ++
 rtl/fb_pattern_writer.sv | 120 ++++++++++++
 tb/tb_fb_pattern_writer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_pattern_writer_if.sv
// fb_pattern_writer_if: control, pixel write port and status between the pattern writer and its host/sink
// Signals: start/abort/mode/color/base (host controls), address/data/we + ready (write handshake),
//          busy/done/frames (status). master = pattern writer, slave = host and sink side.
interface fb_pattern_writer_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 8
);
    logic              start;
    logic              abort;
    logic [1:0]        mode;
    logic [DATA_W-1:0] color;
    logic [ADDR_W-1:0] base;
    logic              ready;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              we;
    logic              busy;
    logic              done;
    logic [7:0]        frames;
    modport master (
        input  start, abort, mode, color, base, ready,
        output address, data, we, busy, done, frames
    );
    modport slave (
        output start, abort, mode, color, base, ready,
        input  address, data, we, busy, done, frames
    );
endinterface

// File: rtl/fb_pattern_writer.sv
// fb_pattern_writer: walks an H_RES x V_RES region at base/stride and writes one of four pixel patterns under a ready handshake
// Ports: clock, reset_n (async active-low), bus (fb_pattern_writer_if.master: start/abort/mode/color/base/ready in,
//        address/data/we/busy/done/frames out).
// Macro FB_PATTERN_CONTINUOUS_EN: when defined, re-latches the inputs after each frame and restarts without idling.
module fb_pattern_writer #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 8,
    parameter int H_RES  = 320,
    parameter int V_RES  = 200,
    parameter int STRIDE = 512,
    parameter int PACE   = 0
) (
    input logic               clock,
    input logic               reset_n,
    fb_pattern_writer_if.master bus
);
    // Counters are at least 4 bits so the xor/checker patterns can always index bits [3:0].
    localparam int XW = ($clog2(H_RES) < 4) ? 4 : $clog2(H_RES);
    localparam int YW = ($clog2(V_RES) < 4) ? 4 : $clog2(V_RES);
    localparam int PW = (PACE < 2) ? 1 : $clog2(PACE);
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_PACE, S_DONE} state_t;
    state_t            state;
    logic [XW-1:0]     x, nx;
    logic [YW-1:0]     y, ny;
    logic [ADDR_W-1:0] row, nrow;
    logic [PW-1:0]     pace_cnt;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] color_q;
    logic              eol, last, accept;
    function automatic logic [DATA_W-1:0] pix(input logic [1:0] m, input logic [DATA_W-1:0] c,
                                              input logic [XW-1:0] px, input logic [YW-1:0] py);
        return m == 2'd0 ? c :
               m == 2'd1 ? {(DATA_W/4){px[3:0] ^ py[3:0]}} :
               m == 2'd2 ? DATA_W'(px) :
               (px[3] ^ py[3]) ? c : ~c;
    endfunction
    always_comb begin
        eol    = x == XW'(H_RES - 1);
        last   = eol && y == YW'(V_RES - 1);
        nx     = eol ? '0 : x + XW'(1);
        ny     = eol ? y + YW'(1) : y;
        nrow   = eol ? row + ADDR_W'(STRIDE) : row;
        accept = bus.we && bus.ready;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            x           <= '0;
            y           <= '0;
            row         <= '0;
            pace_cnt    <= '0;
            mode_q      <= '0;
            color_q     <= '0;
            bus.address <= '0;
            bus.data    <= '0;
            bus.we      <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.frames  <= '0;
        end else if (bus.abort) begin
            state    <= S_IDLE;
            bus.we   <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) begin
                    mode_q      <= bus.mode;
                    color_q     <= bus.color;
                    x           <= '0;
                    y           <= '0;
                    row         <= bus.base;
                    bus.address <= bus.base;
                    bus.data    <= pix(bus.mode, bus.color, '0, '0);
                    bus.we      <= 1'b1;
                    bus.busy    <= 1'b1;
                    state       <= S_WRITE;
                end
                S_WRITE: if (accept) begin
                    pace_cnt <= '0;
                    if (last) begin
                        bus.done   <= 1'b1;
                        bus.frames <= bus.frames + 8'd1;
`ifdef FB_PATTERN_CONTINUOUS_EN
                        mode_q      <= bus.mode;
                        color_q     <= bus.color;
                        x           <= '0;
                        y           <= '0;
                        row         <= bus.base;
                        bus.address <= bus.base;
                        bus.data    <= pix(bus.mode, bus.color, '0, '0);
                        bus.we      <= PACE == 0;
                        state       <= PACE > 0 ? S_PACE : S_WRITE;
`else
                        bus.we   <= 1'b0;
                        bus.busy <= 1'b0;
                        state    <= S_DONE;
`endif
                    end else begin
                        x           <= nx;
                        y           <= ny;
                        row         <= nrow;
                        bus.address <= nrow + ADDR_W'(nx);
                        bus.data    <= pix(mode_q, color_q, nx, ny);
                        bus.we      <= PACE == 0;
                        state       <= PACE > 0 ? S_PACE : S_WRITE;
                    end
                end
                S_PACE: if (pace_cnt == PW'(PACE - 1)) begin
                    bus.we <= 1'b1;
                    state  <= S_WRITE;
                end else begin
                    pace_cnt <= pace_cnt + PW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_pattern_writer.sv
// tb_fb_pattern_writer: directed checks of fill/xor/gradient/checker patterns, backpressure, pacing, abort and continuous mode
module tb_fb_pattern_writer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int cmp = 0;
    int bad = 0;
    int exp_frames = 0;
    int early_done;
    logic [25:0] ad [0:31];
    logic [7:0]  da [0:31];
    always #5 clk = ~clk;
    fb_pattern_writer_if #(.ADDR_W(26), .DATA_W(8)) bus ();
    fb_pattern_writer_if #(.ADDR_W(26), .DATA_W(8)) pbus ();
    fb_pattern_writer #(.ADDR_W(26), .DATA_W(8), .H_RES(4), .V_RES(3), .STRIDE(8), .PACE(0))
        dut (.clock(clk), .reset_n(reset_n), .bus(bus));
    fb_pattern_writer #(.ADDR_W(26), .DATA_W(8), .H_RES(4), .V_RES(3), .STRIDE(8), .PACE(3))
        dut_pace (.clock(clk), .reset_n(reset_n), .bus(pbus));

    task automatic kick(input logic [1:0] m, input logic [7:0] c, input logic [25:0] b);
        @(negedge clk);
        bus.mode = m; bus.color = c; bus.base = b; bus.ready = 1'b1; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic run_frame(input int want, output int got);
        got = 0;
        early_done = 0;
        for (int c = 0; c < 400 && got < want; c++) begin
            @(negedge clk);
            if (bus.done) early_done++;
            if (bus.we && bus.ready) begin
                ad[got] = bus.address; da[got] = bus.data; got++;
            end
        end
    endtask

    task automatic stop;
        @(negedge clk); bus.abort = 1'b1;
        @(negedge clk); bus.abort = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk); @(negedge clk);
        cmp++; if (bus.address !== 26'h0) begin bad++; $display("FAIL reset_address: got %h want 0", bus.address); end
        cmp++; if (bus.data !== 8'h0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.data); end
        cmp++; if (bus.we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", bus.we); end
        cmp++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        cmp++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        cmp++; if (bus.frames !== 8'h0) begin bad++; $display("FAIL reset_frames: got %h want 0", bus.frames); end
        cmp++; if (pbus.we !== 1'b0) begin bad++; $display("FAIL reset_pace_we: got %b want 0", pbus.we); end
        reset_n = 1'b1;
    endtask

    task automatic test_fill;
        int got;
        kick(2'd0, 8'h5A, 26'h100);
        run_frame(12, got);
        cmp++; if (got !== 12) begin bad++; $display("FAIL fill_count: got %0d want 12", got); end
        for (int i = 0; i < got; i++) begin
            cmp++; if (ad[i] !== 26'h100 + 26'((i / 4) * 8 + i % 4)) begin bad++; $display("FAIL fill_addr[%0d]: got %h want %h", i, ad[i], 26'h100 + 26'((i / 4) * 8 + i % 4)); end
            cmp++; if (da[i] !== 8'h5A) begin bad++; $display("FAIL fill_data[%0d]: got %h want 5a", i, da[i]); end
        end
        cmp++; if (early_done !== 0) begin bad++; $display("FAIL fill_early_done: got %0d want 0", early_done); end
        exp_frames++;
        @(negedge clk);
        cmp++; if (bus.done !== 1'b1) begin bad++; $display("FAIL fill_done: got %b want 1", bus.done); end
        cmp++; if (bus.frames !== 8'(exp_frames)) begin bad++; $display("FAIL fill_frames: got %0d want %0d", bus.frames, exp_frames); end
        @(negedge clk);
        cmp++; if (bus.done !== 1'b0) begin bad++; $display("FAIL fill_done_pulse: got %b want 0", bus.done); end
`ifndef FB_PATTERN_CONTINUOUS_EN
        cmp++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL fill_busy_after: got %b want 0", bus.busy); end
        cmp++; if (bus.we !== 1'b0) begin bad++; $display("FAIL fill_we_after: got %b want 0", bus.we); end
`endif
        stop();
    endtask

    task automatic test_xor;
        int got;
        kick(2'd1, 8'hFF, 26'h200);
        run_frame(12, got);
        cmp++; if (got !== 12) begin bad++; $display("FAIL xor_count: got %0d want 12", got); end
        cmp++; if (da[11] !== 8'h11) begin bad++; $display("FAIL xor_px32: got %h want 11", da[11]); end
        cmp++; if (da[5] !== 8'h00) begin bad++; $display("FAIL xor_px11: got %h want 00", da[5]); end
        cmp++; if (da[2] !== 8'h22) begin bad++; $display("FAIL xor_px20: got %h want 22", da[2]); end
        cmp++; if (ad[11] !== 26'h213) begin bad++; $display("FAIL xor_addr32: got %h want 213", ad[11]); end
        exp_frames++;
        @(negedge clk);
        cmp++; if (bus.frames !== 8'(exp_frames)) begin bad++; $display("FAIL xor_frames: got %0d want %0d", bus.frames, exp_frames); end
        stop();
    endtask

    task automatic test_gradient_checker;
        int got;
        kick(2'd2, 8'hC3, 26'h0);
        run_frame(12, got);
        cmp++; if (da[3] !== 8'h03) begin bad++; $display("FAIL grad_px30: got %h want 03", da[3]); end
        cmp++; if (da[6] !== 8'h02) begin bad++; $display("FAIL grad_px21: got %h want 02", da[6]); end
        exp_frames++;
        stop();
        kick(2'd3, 8'hC3, 26'h3FFFFFE);
        run_frame(12, got);
        cmp++; if (da[0] !== 8'h3C) begin bad++; $display("FAIL chk_px00: got %h want 3c", da[0]); end
        cmp++; if (da[11] !== 8'h3C) begin bad++; $display("FAIL chk_px32: got %h want 3c", da[11]); end
        cmp++; if (ad[1] !== 26'h3FFFFFF) begin bad++; $display("FAIL wrap_addr1: got %h want 3ffffff", ad[1]); end
        cmp++; if (ad[2] !== 26'h0) begin bad++; $display("FAIL wrap_addr2: got %h want 0", ad[2]); end
        cmp++; if (ad[4] !== 26'h6) begin bad++; $display("FAIL wrap_addr4: got %h want 6", ad[4]); end
        exp_frames++;
        stop();
    endtask

    task automatic test_backpressure;
        int got = 0;
        int s = 0;
        int hits = 0;
        logic stall;
        kick(2'd0, 8'h77, 26'h40);
        for (int c = 0; c < 400 && got < 12; c++) begin
            @(negedge clk);
            stall = (s > 0 && s < 5) || (s == 0 && bus.we && bus.address == 26'h41);
            if (stall) begin
                cmp++; if (bus.data !== 8'h77 || bus.we !== 1'b1) begin bad++; $display("FAIL bp_hold_data[%0d]: got %h/%b want 77/1", s, bus.data, bus.we); end
                if (s > 0) begin
                    cmp++; if (bus.address !== 26'h41) begin bad++; $display("FAIL bp_hold_addr[%0d]: got %h want 41", s, bus.address); end
                end
                if (s == 2) begin bus.start = 1'b1; bus.base = 26'h999; bus.color = 8'h00; end
                s++;
            end
            bus.ready = !stall;
            if (bus.we && bus.ready) begin
                ad[got] = bus.address; da[got] = bus.data; got++;
                if (bus.address == 26'h41) hits++;
            end
        end
        bus.start = 1'b0; bus.ready = 1'b1;
        cmp++; if (got !== 12) begin bad++; $display("FAIL bp_count: got %0d want 12", got); end
        cmp++; if (hits !== 1) begin bad++; $display("FAIL bp_accept_once: got %0d want 1", hits); end
        cmp++; if (s !== 5) begin bad++; $display("FAIL bp_stall_cycles: got %0d want 5", s); end
        cmp++; if (da[11] !== 8'h77) begin bad++; $display("FAIL bp_latched_color: got %h want 77", da[11]); end
        cmp++; if (ad[11] !== 26'h53) begin bad++; $display("FAIL bp_latched_base: got %h want 53", ad[11]); end
        exp_frames++;
        @(negedge clk);
        cmp++; if (bus.done !== 1'b1) begin bad++; $display("FAIL bp_done: got %b want 1", bus.done); end
        stop();
    endtask

    task automatic test_pacing;
        int got = 0;
        int c0 = 0;
        int prev = 0;
        int lows = 0;
        @(negedge clk);
        pbus.mode = 2'd0; pbus.color = 8'h12; pbus.base = 26'h80; pbus.ready = 1'b1; pbus.start = 1'b1;
        @(posedge clk);
        #1 pbus.start = 1'b0;
        for (int c = 0; c < 400 && got < 12; c++) begin
            @(negedge clk);
            if (got > 0 && !pbus.we) lows++;
            if (pbus.we && pbus.ready) begin
                if (got == 0) c0 = c;
                else begin
                    cmp++; if (c - prev !== 4) begin bad++; $display("FAIL pace_gap[%0d]: got %0d want 4", got, c - prev); end
                end
                prev = c;
                got++;
            end
        end
        cmp++; if (got !== 12) begin bad++; $display("FAIL pace_count: got %0d want 12", got); end
        cmp++; if (prev - c0 + 1 !== 45) begin bad++; $display("FAIL pace_frame_len: got %0d want 45", prev - c0 + 1); end
        cmp++; if (lows !== 33) begin bad++; $display("FAIL pace_idle_total: got %0d want 33", lows); end
        @(negedge clk);
        cmp++; if (pbus.done !== 1'b1) begin bad++; $display("FAIL pace_done: got %b want 1", pbus.done); end
        cmp++; if (pbus.frames !== 8'd1) begin bad++; $display("FAIL pace_frames: got %0d want 1", pbus.frames); end
        pbus.abort = 1'b1;
        @(negedge clk); pbus.abort = 1'b0;
    endtask

    task automatic test_abort;
        int dones = 0;
        int wes = 0;
        kick(2'd0, 8'h33, 26'h300);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.we && bus.address == 26'h30A) begin bus.abort = 1'b1; break; end
        end
        @(negedge clk);
        bus.abort = 1'b0;
        cmp++; if (bus.we !== 1'b0) begin bad++; $display("FAIL abort_we: got %b want 0", bus.we); end
        cmp++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (bus.we) wes++;
        end
        cmp++; if (dones !== 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", dones); end
        cmp++; if (wes !== 0) begin bad++; $display("FAIL abort_stays_idle: got %0d want 0", wes); end
        cmp++; if (bus.frames !== 8'(exp_frames)) begin bad++; $display("FAIL abort_frames: got %0d want %0d", bus.frames, exp_frames); end
        kick(2'd0, 8'h33, 26'h380);
        @(negedge clk);
        cmp++; if (bus.we !== 1'b1 || bus.address !== 26'h380) begin bad++; $display("FAIL abort_restart: got %b/%h want 1/380", bus.we, bus.address); end
        stop();
    endtask

`ifdef FB_PATTERN_CONTINUOUS_EN
    task automatic test_continuous;
        int got = 0;
        int dones = 0;
        int busy_low = 0;
        kick(2'd0, 8'hAA, 26'h500);
        for (int c = 0; c < 400 && got < 24; c++) begin
            @(negedge clk);
            if (!bus.busy) busy_low++;
            if (bus.done) dones++;
            if (got == 6) bus.mode = 2'd2;
            if (bus.we && bus.ready) begin
                ad[got] = bus.address; da[got] = bus.data; got++;
            end
        end
        @(negedge clk);
        if (bus.done) dones++;
        exp_frames += 2;
        cmp++; if (got !== 24) begin bad++; $display("FAIL cont_count: got %0d want 24", got); end
        cmp++; if (da[11] !== 8'hAA) begin bad++; $display("FAIL cont_f1_data: got %h want aa", da[11]); end
        cmp++; if (da[15] !== 8'h03) begin bad++; $display("FAIL cont_f2_px30: got %h want 03", da[15]); end
        cmp++; if (da[18] !== 8'h02) begin bad++; $display("FAIL cont_f2_px21: got %h want 02", da[18]); end
        cmp++; if (ad[12] !== 26'h500) begin bad++; $display("FAIL cont_f2_base: got %h want 500", ad[12]); end
        cmp++; if (dones !== 2) begin bad++; $display("FAIL cont_dones: got %0d want 2", dones); end
        cmp++; if (busy_low !== 0) begin bad++; $display("FAIL cont_busy: got %0d low cycles want 0", busy_low); end
        cmp++; if (bus.frames !== 8'(exp_frames)) begin bad++; $display("FAIL cont_frames: got %0d want %0d", bus.frames, exp_frames); end
        stop();
    endtask
`endif

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 2'd0; bus.color = 8'h0; bus.base = 26'h0; bus.ready = 1'b1;
        pbus.start = 1'b0; pbus.abort = 1'b0; pbus.mode = 2'd0; pbus.color = 8'h0; pbus.base = 26'h0; pbus.ready = 1'b1;
        test_reset();
        test_fill();
        test_xor();
        test_gradient_checker();
        test_backpressure();
        test_pacing();
        test_abort();
`ifdef FB_PATTERN_CONTINUOUS_EN
        test_continuous();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
